// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared types and helpers for the iterative square-root unit.
//   state_t   : controller states (IDLE, ITER, DONE)
//   cnt_width : width of the iteration counter for a given radicand width
// -----------------------------------------------------------------------------
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter runs from WIDTH/2-1 down to 0.
  // At least one bit is kept so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/sqrt_iter_datapath.sv
// -----------------------------------------------------------------------------
// sqrt_iter_datapath
// Radicand, root and remainder registers plus the trial subtractor of the
// digit-by-digit (radix-4 input, radix-2 root) square-root recurrence.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   load         : capture din and clear root/remainder
//   step         : perform one recurrence step (consumes top 2 radicand bits)
//   din          : unsigned radicand, WIDTH bits
//   root         : partial/final root, WIDTH/2 bits
//   rem          : partial/final remainder, WIDTH/2+1 bits
// -----------------------------------------------------------------------------
module sqrt_iter_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int HW = WIDTH / 2;
  localparam int AW = HW + 2;  // trial/remainder arithmetic width

  logic [WIDTH-1:0] rad_q;
  logic [HW-1:0]    root_q;
  logic [AW-1:0]    rem_q;

  logic [AW-1:0]    r_trial;
  logic [AW-1:0]    t_trial;
  logic             take;
  logic [AW-1:0]    rem_next;
  logic [HW-1:0]    root_next;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), so no latch is inferred.
  always_comb begin
    r_trial   = '0;
    t_trial   = '0;
    take      = 1'b0;
    rem_next  = rem_q;
    root_next = root_q;

    r_trial   = (rem_q << 2) | AW'(rad_q[WIDTH-1 -: 2]);
    t_trial   = (AW'(root_q) << 2) | AW'(1);
    take      = (r_trial >= t_trial);
    rem_next  = take ? (r_trial - t_trial) : r_trial;
    root_next = {root_q[HW-2:0], take};
  end

  // NOTE: registered state uses non-blocking assignments only.
  // NOTE: these are a handful of flops, not a memory, so they are all reset
  // to give a clean root=0 / rem=0 after reset and after an aborted job.
  always_ff @(posedge clock) begin
    if (reset) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
      rad_q  <= din;
      root_q <= '0;
      rem_q  <= '0;
    end else if (step) begin
      rad_q  <= rad_q << 2;
      root_q <= root_next;
      rem_q  <= rem_next;
    end
  end

  assign root = root_q;
  // The final remainder is at most 2*root, so the top bit of rem_q is only
  // ever used by intermediate r' values.
  assign rem  = rem_q[HW:0];

endmodule

// File: rtl/sqrt_iter_unit.sv
// -----------------------------------------------------------------------------
// sqrt_iter_unit
// Iterative integer square root: root = floor(sqrt(din)), fixed latency of
// WIDTH/2+1 cycles from accept to the valid pulse.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : request; accepted only while ready=1
//   din          : unsigned radicand (WIDTH bits, WIDTH even, 4..32)
//   ready        : high in IDLE
//   busy         : high in ITER and DONE
//   valid        : one-cycle pulse with the completed result
//   root         : floor(sqrt(din)), held until the next accept
//   rem          : din - root*root (only when SQRT_REMAINDER_EN is defined)
// Configuration macro: SQRT_REMAINDER_EN exposes the rem port.
// -----------------------------------------------------------------------------
module sqrt_iter_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  output logic               ready,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH/2-1:0] root
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [WIDTH/2:0]   rem
`endif
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH / 2 - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             step;
  logic [WIDTH/2:0] rem_int;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= CNT_INIT;
      end else if (step) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        step = 1'b1;
        // Counter was loaded with WIDTH/2-1, so the step taken while it reads
        // 0 is the WIDTH/2-th and last one.
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == ITER) || (state_q == DONE);
  assign valid = (state_q == DONE);

  sqrt_iter_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .din   (din),
    .root  (root),
    .rem   (rem_int)
  );

`ifdef SQRT_REMAINDER_EN
  assign rem = rem_int;
`else
  // Remainder register still exists internally; its value is simply not exported.
  logic rem_unused;
  assign rem_unused = ^rem_int;
`endif

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_sqrt_iter_unit
// Scoreboard bench for sqrt_iter_unit. Two instances: WIDTH=16 for directed and
// random jobs, WIDTH=4 for an exhaustive back-to-back sweep with start held.
// Expected results come from a floor(sqrt) search model and are queued at the
// accept edge; monitors pop and compare whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_sqrt_iter_unit;

  typedef struct {
    int     root;
    int     rem;
    longint due;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start16;
  logic [15:0] din16;
  logic       ready16, busy16, valid16;
  logic [7:0] root16;
  logic       start4;
  logic [3:0] din4;
  logic       ready4, busy4, valid4;
  logic [1:0] root4;
`ifdef SQRT_REMAINDER_EN
  logic [8:0] rem16;
  logic [2:0] rem4;
`endif

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  exp_t   q16[$];
  exp_t   q4[$];

  always @(posedge clock) cyc <= cyc + 1;

  sqrt_iter_unit #(.WIDTH(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .start (start16),
    .din   (din16),
    .ready (ready16),
    .busy  (busy16),
    .valid (valid16),
    .root  (root16)
`ifdef SQRT_REMAINDER_EN
    ,
    .rem   (rem16)
`endif
  );

  sqrt_iter_unit #(.WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .start (start4),
    .din   (din4),
    .ready (ready4),
    .busy  (busy4),
    .valid (valid4),
    .root  (root4)
`ifdef SQRT_REMAINDER_EN
    ,
    .rem   (rem4)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Largest r with r*r <= v.
  function automatic int ref_root(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic exp_t make_exp(input int v, input longint due);
    exp_t e;
    e.root = ref_root(v);
    e.rem  = v - e.root * e.root;
    e.due  = due;
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (valid16) begin
      if (q16.size() == 0) begin
        check("valid16_unexpected", valid16, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("root16", root16, e.root);
        check("latency16", cyc, e.due);
`ifdef SQRT_REMAINDER_EN
        check("rem16", rem16, e.rem);
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (valid4) begin
      if (q4.size() == 0) begin
        check("valid4_unexpected", valid4, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("root4", root4, e.root);
        check("latency4", cyc, e.due);
`ifdef SQRT_REMAINDER_EN
        check("rem4", rem4, e.rem);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issue one request to dut16; returns on the falling edge of ITER cycle 1.
  task automatic issue16(input int v, input bit expect_result);
    int waited = 0;
    @(negedge clock);
    while (!ready16 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!ready16) begin
      check("ready16_timeout", ready16, 1);
    end else begin
      start16 = 1'b1;
      din16   = 16'(v);
      @(posedge clock);
      #1;
      // valid is due in the WIDTH/2+1-th cycle, i.e. after 8 more edges
      if (expect_result) q16.push_back(make_exp(v, cyc + 8));
      @(negedge clock);
      start16 = 1'b0;
      din16   = 16'($urandom);  // must not disturb the running job
    end
  endtask

  task automatic drain16();
    int waited = 0;
    while (q16.size() != 0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("drain16", q16.size(), 0);
  endtask

  task automatic drain4();
    int waited = 0;
    while (q4.size() != 0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("drain4", q4.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint prev_acc;
    reset   = 1'b1;
    start16 = 1'b0;
    din16   = '0;
    start4  = 1'b0;
    din4    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_ready16", ready16, 1);
    check("reset_busy16",  busy16,  0);
    check("reset_valid16", valid16, 0);
    check("reset_root16",  root16,  0);
    check("reset_ready4",  ready4,  1);
    reset = 1'b0;

    // Directed values
    issue16(0, 1);
    drain16();
    issue16(144, 1);
    issue16(145, 1);
    issue16(65535, 1);
    issue16(65025, 1);
    issue16(65024, 1);
    issue16(1, 1);
    drain16();

    // start pulsed during ITER must be ignored
    issue16(144, 1);
    @(negedge clock);
    start16 = 1'b1;
    din16   = 16'd99;
    check("ignore_ready16", ready16, 0);
    check("ignore_busy16",  busy16,  1);
    @(negedge clock);
    start16 = 1'b0;
    drain16();
    repeat (20) @(negedge clock);
    check("idle_after_ignore16", ready16, 1);

    // Reset in the 4th ITER cycle aborts with no valid pulse
    issue16(1000, 0);
    repeat (3) @(negedge clock);
    check("abort_busy16", busy16, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready16", ready16, 1);
    check("abort_busy16_after", busy16, 0);
    check("abort_root16", root16, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    // Random jobs
    for (int i = 0; i < 25; i++) begin
      issue16(int'($urandom_range(0, 65535)), 1);
    end
    drain16();

    // WIDTH=4 exhaustive, start held high: one accept every 4 cycles
    @(negedge clock);
    start4   = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      int waited = 0;
      while (!ready4 && waited < 50) begin
        @(negedge clock);
        waited++;
      end
      din4 = 4'(i);
      @(posedge clock);
      #1;
      if (i > 0) check("spacing4", cyc - prev_acc, 4);
      prev_acc = cyc;
      q4.push_back(make_exp(i, cyc + 2));
      @(negedge clock);
    end
    start4 = 1'b0;
    drain4();
    repeat (10) @(negedge clock);
    check("idle4_end", ready4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
